// File: rtl/mux_scan.sv
// mux_scan: registered N-channel multiplexer with manual-select and auto-scan modes.
//
// Every output sample is registered together with the channel index that produced it,
// so f and cur_sel always move on the same edge.
//
// Optional feature: define MUXSCAN_MASK_EN to add the en_mask port (one enable bit per
// channel). Without it every channel is treated as enabled.
//
// Ports:
//   clk      in   clock, rising edge
//   rst      in   synchronous reset, active-high (wins over start)
//   a        in   channel data, channel i at [i*WIDTH +: WIDTH]
//   sel      in   manual channel select / scan start channel
//   mode     in   0 = manual, 1 = scan; sampled only on start from idle
//   dwell    in   each scanned channel is held dwell+1 cycles
//   start    in   single-cycle strobe: start from idle, stop when running
//   en_mask  in   (MUXSCAN_MASK_EN only) per-channel enable
//   f        out  registered selected data
//   cur_sel  out  channel index that produced f
//   f_valid  out  f/cur_sel hold a valid sample
//   wrap     out  one-cycle pulse when the scan moves to a lower channel index
module mux_scan #(
  parameter int unsigned WIDTH   = 1,
  parameter int unsigned CH      = 16,
  parameter int unsigned SELW    = 4,
  parameter int unsigned DWELL_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CH*WIDTH-1:0]   a,
  input  logic [SELW-1:0]       sel,
  input  logic                  mode,
  input  logic [DWELL_W-1:0]    dwell,
  input  logic                  start,
`ifdef MUXSCAN_MASK_EN
  input  logic [CH-1:0]         en_mask,
`endif
  output logic [WIDTH-1:0]      f,
  output logic [SELW-1:0]       cur_sel,
  output logic                  f_valid,
  output logic                  wrap
);

  typedef enum logic [1:0] {
    StIdle,
    StManual,
    StScan
  } state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     f_q, f_d;
  logic [SELW-1:0]      cur_sel_q, cur_sel_d;
  logic                 f_valid_q, f_valid_d;
  logic                 wrap_q, wrap_d;
  logic [SELW-1:0]      ptr_q, ptr_d;
  logic [DWELL_W-1:0]   cnt_q, cnt_d;
  // Set once the current scan run has emitted a sample; keeps the initial load from
  // being mistaken for a wrap.
  logic                 scan_run_q, scan_run_d;

  logic [CH-1:0]        chan_en;
  logic                 any_en;

`ifdef MUXSCAN_MASK_EN
  assign chan_en = en_mask;
`else
  assign chan_en = {CH{1'b1}};
`endif

  assign any_en = |chan_en;

  // Channel lookups. Out-of-range indices read as data 0, disabled.
  logic [WIDTH-1:0] sel_data, ptr_data;
  logic             sel_en, ptr_en;

  always_comb begin
    sel_data = '0;
    sel_en   = 1'b0;
    ptr_data = '0;
    ptr_en   = 1'b0;
    for (int i = 0; i < int'(CH); i++) begin
      if (sel == SELW'(i)) begin
        sel_data = a[i*WIDTH +: WIDTH];
        sel_en   = chan_en[i];
      end
      if (ptr_q == SELW'(i)) begin
        ptr_data = a[i*WIDTH +: WIDTH];
        ptr_en   = chan_en[i];
      end
    end
  end

  // Scan start channel: out-of-range select starts at channel 0.
  logic            sel_in_range;
  logic [SELW-1:0] ptr_start;

  assign sel_in_range = (32'(sel) < CH);
  assign ptr_start    = sel_in_range ? sel : '0;

  // Next enabled channel above ptr, else the lowest enabled channel (wrap-around).
  // The descending loop leaves the lowest qualifying index in each candidate.
  logic [SELW-1:0] nxt_hi, nxt_lo, nxt_ptr;
  logic            hi_found;

  always_comb begin
    nxt_hi   = '0;
    nxt_lo   = ptr_q;
    hi_found = 1'b0;
    for (int i = int'(CH) - 1; i >= 0; i--) begin
      if (chan_en[i]) begin
        nxt_lo = SELW'(i);
        if (i > int'(ptr_q)) begin
          nxt_hi   = SELW'(i);
          hi_found = 1'b1;
        end
      end
    end
    nxt_ptr = hi_found ? nxt_hi : nxt_lo;
  end

  always_comb begin
    state_d    = state_q;
    f_d        = f_q;
    cur_sel_d  = cur_sel_q;
    f_valid_d  = f_valid_q;
    wrap_d     = 1'b0;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    scan_run_d = scan_run_q;

    unique case (state_q)
      StIdle: begin
        f_valid_d  = 1'b0;
        scan_run_d = 1'b0;
        if (start) begin
          if (mode) begin
            state_d = StScan;
            ptr_d   = ptr_start;
            cnt_d   = '0;
          end else begin
            state_d = StManual;
          end
        end
      end

      StManual: begin
        if (start) begin
          // Stop: f and cur_sel freeze, only the valid flag drops.
          state_d   = StIdle;
          f_valid_d = 1'b0;
        end else begin
          f_d       = sel_en ? sel_data : '0;
          cur_sel_d = sel;
          f_valid_d = sel_en;
        end
      end

      StScan: begin
        if (start) begin
          state_d    = StIdle;
          f_valid_d  = 1'b0;
          scan_run_d = 1'b0;
        end else if (!any_en) begin
          // Nothing to scan: hold data, index, pointer and counter.
          f_valid_d = 1'b0;
        end else begin
          scan_run_d = 1'b1;
          cur_sel_d  = ptr_q;
          f_valid_d  = ptr_en;
          if (ptr_en) begin
            f_d = ptr_data;
          end
          wrap_d = scan_run_q && (ptr_q < cur_sel_q);
          if (cnt_q == dwell) begin
            cnt_d = '0;
            ptr_d = nxt_ptr;
          end else begin
            cnt_d = cnt_q + DWELL_W'(1);
          end
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      f_q        <= '0;
      cur_sel_q  <= '0;
      f_valid_q  <= 1'b0;
      wrap_q     <= 1'b0;
      ptr_q      <= '0;
      cnt_q      <= '0;
      scan_run_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      f_q        <= f_d;
      cur_sel_q  <= cur_sel_d;
      f_valid_q  <= f_valid_d;
      wrap_q     <= wrap_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      scan_run_q <= scan_run_d;
    end
  end

  assign f       = f_q;
  assign cur_sel = cur_sel_q;
  assign f_valid = f_valid_q;
  assign wrap    = wrap_q;

endmodule

// File: doc/mux_scan.md
# mux_scan

Parametrised, registered N-channel multiplexer with a manual-select mode and an auto-scan mode. In scan mode the selector advances through channels on a programmable dwell interval. Output data and the selected channel index are registered together, so every output sample is tagged with its source channel. Used to time-multiplex status and sense lines onto a single observation path.

## Interface
Parameters:
- WIDTH, 1, bits per channel
- CH, 16, number of channels (>= 2)
- SELW, 4, selector width; 2**SELW >= CH
- DWELL_W, 8, dwell counter width

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous reset, active-high
- a  in  CH*WIDTH  channel data; channel i at bits [i*WIDTH +: WIDTH]
- sel  in  SELW  manual channel select; scan start channel
- mode  in  1  0 = manual, 1 = scan; sampled only on start
- dwell  in  DWELL_W  scan hold: each channel held dwell+1 cycles; sampled continuously
- start  in  1  single-cycle strobe; starts from IDLE, stops when running
- f  out  WIDTH  registered selected data
- cur_sel  out  SELW  channel index that produced f
- f_valid  out  1  f/cur_sel hold a valid sample
- wrap  out  1  one-cycle pulse when scan returns to channel 0

## Operation
- Reset: state IDLE; f=0, cur_sel=0, f_valid=0, wrap=0; internal ptr=0, dwell count cnt=0.
- States: IDLE, MANUAL, SCAN.
- IDLE: f and cur_sel hold, f_valid=0. start&&!mode -> MANUAL. start&&mode -> SCAN, ptr<=sel (sel>=CH loads 0), cnt<=0.
- MANUAL: each cycle f<=a[sel], cur_sel<=sel, f_valid<=1. sel>=CH: f<=0, cur_sel<=sel, f_valid<=0.
- SCAN: each cycle f<=a[ptr], cur_sel<=ptr, f_valid<=1. When cnt==dwell: cnt<=0, ptr<=(ptr==CH-1)?0:ptr+1. Otherwise cnt<=cnt+1.
- wrap: asserted in the cycle when cur_sel changes from CH-1 to 0. It is not asserted for the initial load at ptr=0.
- start in MANUAL or SCAN -> IDLE next cycle. f_valid drops to 0 at that edge, and f and cur_sel freeze.
- mode changes while running are ignored until the next start from IDLE.
- dwell lowered below the current cnt: advance when cnt wraps past the counter width. Drivers must change dwell only in IDLE. The bench does not check this case.
- rst has priority over start in any state. A mid-scan rst returns all outputs to their reset values on the next edge.

## Timing
- Latency: 1 cycle from a/sel to f. f at edge t+1 equals a[ptr or sel] sampled at edge t.
- First valid sample: the edge after the start edge.
- SCAN with dwell=D: each channel is valid for exactly D+1 consecutive cycles. A full rotation takes CH*(D+1) cycles. With D=0 the scan advances every cycle.
- cur_sel and f are always updated on the same edge and are never skewed.

## Configuration
- MUXSCAN_MASK_EN defined: adds port en_mask in CH, one bit per channel, 1 = enabled.
  - SCAN advances to the next enabled channel in ascending order, with wrap-around.
  - A start channel that is disabled advances on the first dwell expiry, and f_valid=0 while on it.
  - en_mask==0 in SCAN: f_valid=0, f holds, ptr holds.
  - MANUAL with a disabled sel: f<=0, f_valid=0.
  - wrap pulses on any transition to a lower index.
- MUXSCAN_MASK_EN undefined: no en_mask port, and all channels are treated as enabled.

## Test plan
- Manual, WIDTH=1, CH=16, a=16'h3f0a: sel=0 then 1, 6, 12 (5 cycles each) -> f=0, 1, 0, 1 one cycle after each sel change; f_valid=1 throughout.
- Scan, dwell=0, sel=14, a=16'h3f0a -> cur_sel sequence 14, 15, 0, 1; f=0, 0, 0, 1; wrap=1 only in the cycle cur_sel=0.
- Scan, dwell=2, CH=4, WIDTH=8, a={8'h44,8'h33,8'h22,8'h11} -> f=11,11,11,22,22,22,33,... each held 3 cycles.
- Stop and reset: start during SCAN -> f_valid=0 next cycle with f frozen. In a separate run, rst mid-scan -> f=0, cur_sel=0, f_valid=0, wrap=0 next edge; a start in the same cycle as rst is ignored.
- Out-of-range (CH=12, SELW=4): manual sel=13 -> f=0, f_valid=0. Scan started with sel=13 -> first cur_sel=0.
- MUXSCAN_MASK_EN, CH=4, en_mask=4'b1010, dwell=0, sel=0 -> cur_sel 0 (f_valid=0), then 1, 3, 1, 3. wrap pulses on each 3->1 transition. en_mask=0 -> f_valid=0 and f held.
